// File: rtl/interest_parser_if.sv
// Byte-serial ingress and parsed-interest egress bundle for interest_parser.
// master drives packet bytes in; slave is the parser.
interface interest_parser_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] prefix;
    logic [5:0]  len;
    logic        out_bit;
    logic        parse_error;
    logic [7:0]  drop_count;

    modport master (
        output in_byte, in_valid, in_last,
        input  in_ready, prefix, len, out_bit, parse_error, drop_count
    );

    modport slave (
        input  in_byte, in_valid, in_last,
        output in_ready, prefix, len, out_bit, parse_error, drop_count
    );
endinterface

// File: rtl/interest_parser.sv
// NDN interest TLV front-end: validates type/length framing, packs name bytes
// MSB-first into a 64-bit prefix, and drains and counts malformed packets.
module interest_parser #(
    parameter logic [7:0]  INTEREST_TYPE  = 8'h05,
    parameter int unsigned MAX_NAME_BYTES = 7
) (
    input  logic               clk,
    input  logic               rst,
    interest_parser_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        NAME,
        EMIT,
        DROP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_name_len;
    logic [2:0]  r_cnt;
    logic [63:0] r_shift;
    logic [63:0] r_prefix;
    logic [5:0]  r_len;
    logic        r_err;
    logic [7:0]  r_drop_count;

    logic        w_ready;
    logic        w_xfer;
    logic        w_err;
    logic        w_len_ok;
    logic        w_name_last;
    logic [63:0] w_shift;

    assign w_ready     = (r_state != EMIT);
    assign w_xfer      = bus.in_valid && w_ready;
    assign w_len_ok    = (bus.in_byte >= 8'd1) && (bus.in_byte <= 8'(MAX_NAME_BYTES));
    assign w_name_last = (r_cnt == (r_name_len - 3'd1));

    // Name byte k lands at bit offset 8*(7-k); ~r_cnt is 7-k in three bits.
    always_comb begin
        w_shift = r_shift;
        w_shift[{~r_cnt, 3'b000} +: 8] = bus.in_byte;
    end

    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        case (r_state)
            IDLE: if (w_xfer) begin
                if (bus.in_byte == INTEREST_TYPE && !bus.in_last) begin
                    w_next_state = LEN;
                end else begin
                    w_err        = 1'b1;
                    w_next_state = bus.in_last ? IDLE : DROP;
                end
            end
            LEN: if (w_xfer) begin
                if (w_len_ok && !bus.in_last) begin
                    w_next_state = NAME;
                end else begin
                    w_err        = 1'b1;
                    w_next_state = bus.in_last ? IDLE : DROP;
                end
            end
            NAME: if (w_xfer) begin
                if (w_name_last) begin
                    if (bus.in_last) begin
                        w_next_state = EMIT;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = DROP;
                    end
                end else if (bus.in_last) begin
                    w_err        = 1'b1;
                    w_next_state = IDLE;
                end
            end
            EMIT: w_next_state = IDLE;
            DROP: if (w_xfer && bus.in_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_name_len   <= '0;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_prefix     <= '0;
            r_len        <= '0;
            r_err        <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err;
            if (w_err && r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (r_state == LEN && w_xfer && w_next_state == NAME) begin
                r_name_len <= bus.in_byte[2:0];
                r_shift    <= '0;
                r_cnt      <= '0;
            end
            if (r_state == NAME && w_xfer) begin
                r_shift <= w_shift;
                r_cnt   <= r_cnt + 3'd1;
            end
            if (r_state == NAME && w_next_state == EMIT) begin
                r_prefix <= w_shift;
                r_len    <= {r_name_len, 3'b000};
            end
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.prefix      = r_prefix;
    assign bus.len         = r_len;
    assign bus.out_bit     = (r_state == EMIT);
    assign bus.parse_error = r_err;
    assign bus.drop_count  = r_drop_count;

endmodule
